// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing constants, rgb24 pixel type and test-pattern colours
package vga_pkg;

  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24;

  localparam rgb24 C_WHITE   = 24'hffffff;
  localparam rgb24 C_YELLOW  = 24'hffff00;
  localparam rgb24 C_CYAN    = 24'h00ffff;
  localparam rgb24 C_GREEN   = 24'h00ff00;
  localparam rgb24 C_MAGENTA = 24'hff00ff;
  localparam rgb24 C_RED     = 24'hff0000;
  localparam rgb24 C_BLUE    = 24'h0000ff;
  localparam rgb24 C_BLACK   = 24'h000000;

  // Eight 80-pixel colour bars across the visible line.
  function automatic rgb24 bar_colour(input logic [9:0] x);
    if (x < 10'd80)       return C_WHITE;
    else if (x < 10'd160) return C_YELLOW;
    else if (x < 10'd240) return C_CYAN;
    else if (x < 10'd320) return C_GREEN;
    else if (x < 10'd400) return C_MAGENTA;
    else if (x < 10'd480) return C_RED;
    else if (x < 10'd560) return C_BLUE;
    else                  return C_BLACK;
  endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// rtl/vga_timing_cnt.sv - h/v pixel counters with active-region, sync and address decode
module vga_timing_cnt #(
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BACK   = vga_pkg::H_BACK,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FRONT  = vga_pkg::H_FRONT,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BACK   = vga_pkg::V_BACK,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FRONT  = vga_pkg::V_FRONT
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       pclk_en,
  output logic [9:0] h_addr,
  output logic [9:0] v_addr,
  output logic       rd_en,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       wrap
);

  localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] H_ACT_S = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_E = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_ACT_S = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_E = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] H_SYNC_E = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_E = 10'(V_SYNC);

  logic [9:0] h_cnt, v_cnt;
  logic       h_end, v_end, h_act, v_act;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pclk_en) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign h_act = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
  assign v_act = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
  assign rd_en = h_act & v_act;

  // Subtraction only takes effect inside the active window, so it never underflows.
  assign h_addr  = rd_en ? h_cnt - H_ACT_S : '0;
  assign v_addr  = rd_en ? v_cnt - V_ACT_S : '0;
  assign hsync_d = ~(h_cnt < H_SYNC_E);
  assign vsync_d = ~(v_cnt < V_SYNC_E);
  assign wrap    = h_end & v_end;

endmodule

// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA timing generator and registered pixel output stage
// Optional colour-bar generator with pattern_sel input: define VGA_TEST_PATTERN_EN.
module vga_ctrl #(
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BACK   = vga_pkg::H_BACK,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FRONT  = vga_pkg::H_FRONT,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BACK   = vga_pkg::V_BACK,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FRONT  = vga_pkg::V_FRONT
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        pclk_en,
  input  logic [23:0] vga_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        rd_en,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  import vga_pkg::*;

  logic hsync_d, vsync_d, wrap;
  rgb24 pix_nxt, pix;

  vga_timing_cnt #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
  ) u_cnt (
    .clkin(clkin), .rst(rst), .pclk_en(pclk_en),
    .h_addr(h_addr), .v_addr(v_addr), .rd_en(rd_en),
    .hsync_d(hsync_d), .vsync_d(vsync_d), .wrap(wrap)
  );

`ifdef VGA_TEST_PATTERN_EN
  always_comb begin
    pix_nxt = '0;
    if (rd_en) pix_nxt = pattern_sel ? bar_colour(h_addr) : rgb24'(vga_data);
  end
`else
  always_comb begin
    pix_nxt = '0;
    if (rd_en) pix_nxt = vga_data;
  end
`endif

  // Syncs and pixel share one register stage so they stay aligned.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      valid <= 1'b0;
      pix   <= '0;
    end else if (pclk_en) begin
      hsync <= hsync_d;
      vsync <= vsync_d;
      valid <= rd_en;
      pix   <= pix_nxt;
    end
  end

  // Updates every clkin so the pulse lasts one clkin even at reduced pixel rate.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) frame_start <= 1'b0;
    else      frame_start <= pclk_en & wrap;
  end

  assign vga_r = pix.r;
  assign vga_g = pix.g;
  assign vga_b = pix.b;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - scoreboard bench: full-timing vga_ctrl plus a shrunken-timing copy for frame wraps
`timescale 1ns/1ps
module tb_vga_ctrl;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vl;
    logic [23:0] rgb;
  } regs_t;

  typedef struct {
    regs_t r;
    int    h, v, ha, va;
    logic  act, pat;
  } exp_t;

  localparam regs_t RST_REGS = {1'b1, 1'b1, 1'b0, 24'h0};

  logic        clkin = 1'b0;
  logic        rst = 1'b0;
  logic        pclk_en = 1'b0;
  logic        psel = 1'b0;
  logic [23:0] vga_data [2];
  logic [9:0]  h_addr [2], v_addr [2];
  logic        rd_en [2], hsync [2], vsync [2], valid [2], frame_start [2];
  logic [7:0]  vga_r [2], vga_g [2], vga_b [2];

  always #5 clkin = ~clkin;

  vga_ctrl u_full (
    .clkin(clkin), .rst(rst), .pclk_en(pclk_en), .vga_data(vga_data[0]),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(psel),
`endif
    .h_addr(h_addr[0]), .v_addr(v_addr[0]), .rd_en(rd_en[0]),
    .hsync(hsync[0]), .vsync(vsync[0]), .valid(valid[0]),
    .vga_r(vga_r[0]), .vga_g(vga_g[0]), .vga_b(vga_b[0]),
    .frame_start(frame_start[0])
  );

  vga_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(2)
  ) u_small (
    .clkin(clkin), .rst(rst), .pclk_en(pclk_en), .vga_data(vga_data[1]),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(psel),
`endif
    .h_addr(h_addr[1]), .v_addr(v_addr[1]), .rd_en(rd_en[1]),
    .hsync(hsync[1]), .vsync(vsync[1]), .valid(valid[1]),
    .vga_r(vga_r[1]), .vga_g(vga_g[1]), .vga_b(vga_b[1]),
    .frame_start(frame_start[1])
  );

  int p_hs [2] = '{96, 4};
  int p_hb [2] = '{48, 3};
  int p_ha [2] = '{640, 8};
  int p_ht [2] = '{800, 17};
  int p_vs [2] = '{2, 1};
  int p_vb [2] = '{33, 2};
  int p_va [2] = '{480, 4};
  int p_vt [2] = '{525, 9};

  int    mh [2], mv [2];
  regs_t held [2];
  logic  fs_exp [2];
  exp_t  q0 [$], q1 [$];
  int    checks = 0, errors = 0;
  int    hs_low = 0, vs_low = 0, en_cnt1 = 0, last_fs = -1;
  bit    count_syncs = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mem_word(input int i, input int ha, input int va);
    if (i == 0 && ha == 0 && va == 0) return 24'h123456;
    return 24'((ha * 40503 + va * 977 + i * 131) ^ 32'h005a5a5a);
  endfunction

  function automatic logic [23:0] bar(input int ha);
    logic [23:0] t [8];
    t = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
          24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};
    return t[ha / 80];
  endfunction

  task automatic cycle(input logic en);
    logic act, eff;
    int   ha, va, hst, vst;
    exp_t e;
    @(negedge clkin);
    pclk_en = en;
    eff = en & rst;
    for (int i = 0; i < 2; i++) begin
      hst = p_hs[i] + p_hb[i];
      vst = p_vs[i] + p_vb[i];
      act = (mh[i] >= hst) && (mh[i] < hst + p_ha[i]) && (mv[i] >= vst) && (mv[i] < vst + p_va[i]);
      ha  = act ? mh[i] - hst : 0;
      va  = act ? mv[i] - vst : 0;
      vga_data[i] = act ? mem_word(i, ha, va) : 24'($urandom);
      check(i == 0 ? "stage0_full" : "stage0_small",
            {rd_en[i], h_addr[i], v_addr[i]}, {act, 10'(ha), 10'(va)});
      if (i == 0 && mv[0] == 35 && mh[0] == 144)
        check("first_active", {rd_en[0], h_addr[0], v_addr[0]}, {1'b1, 10'd0, 10'd0});
      if (i == 0 && mv[0] == 35 && mh[0] == 783)
        check("last_col", {rd_en[0], h_addr[0]}, {1'b1, 10'd639});
      if (i == 0 && mv[0] == 35 && mh[0] == 784)
        check("front_porch", rd_en[0], 1'b0);
      fs_exp[i] = 1'b0;
      if (eff) begin
        e.r.hs  = !(mh[i] < p_hs[i]);
        e.r.vs  = !(mv[i] < p_vs[i]);
        e.r.vl  = act;
        e.r.rgb = !act ? 24'h0 : (PAT && psel) ? bar(ha) : vga_data[i];
        e.h = mh[i]; e.v = mv[i]; e.ha = ha; e.va = va;
        e.act = act; e.pat = PAT && psel;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        fs_exp[i] = (mh[i] == p_ht[i] - 1) && (mv[i] == p_vt[i] - 1);
        if (mh[i] == p_ht[i] - 1) begin
          mh[i] = 0;
          mv[i] = (mv[i] == p_vt[i] - 1) ? 0 : mv[i] + 1;
        end else begin
          mh[i] = mh[i] + 1;
        end
      end
    end
    @(posedge clkin);
    #1;
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "frame_start_full" : "frame_start_small", frame_start[i], fs_exp[i]);
      if (eff) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          held[i] = e.r;
          if (i == 0 && e.act && !e.pat && e.ha == 0 && e.va == 0)
            check("pix_123456", {valid[0], vga_r[0], vga_g[0], vga_b[0]}, {1'b1, 24'h123456});
          if (i == 0 && e.act && e.pat && (e.ha == 0 || e.ha == 79 || e.ha == 80 || e.ha == 639))
            check("bar_colour", {vga_r[0], vga_g[0], vga_b[0]},
                  e.ha == 80 ? 24'hffff00 : e.ha == 639 ? 24'h000000 : 24'hffffff);
          if (i == 0 && count_syncs) begin
            if (!hsync[0]) hs_low++;
            if (!vsync[0]) vs_low++;
            if (e.h == 799) begin
              check("hsync_width", hs_low, 96);
              hs_low = 0;
            end
            if (e.h == 799 && e.v == 3) check("vsync_width", vs_low, 1600);
          end
          if (i == 1) begin
            en_cnt1++;
            if (frame_start[1]) begin
              if (last_fs >= 0) check("frame_period", en_cnt1 - last_fs, 153);
              last_fs = en_cnt1;
            end
          end
        end
      end
      check(i == 0 ? "regs_full" : "regs_small",
            {hsync[i], vsync[i], valid[i], vga_r[i], vga_g[i], vga_b[i]}, held[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i] = 0;
      mv[i] = 0;
      held[i] = RST_REGS;
    end
    q0.delete();
    q1.delete();
    last_fs = -1;
  endtask

  initial begin
    model_reset();
    vga_data[0] = '0;
    vga_data[1] = '0;
    repeat (3) cycle(1'b1);
    rst = 1'b1;
    count_syncs = 1'b1;
    for (int n = 0; n < 40000 && !(mv[0] == 37 && mh[0] == 0); n++) begin
      psel = (mv[0] == 36);
      cycle(1'b1);
    end
    psel = 1'b0;
    count_syncs = 1'b0;
    for (int n = 0; n < 3000; n++) cycle(n % 2 == 0);
    for (int n = 0; n < 2000 && mh[0] != 300; n++) cycle(1'b1);
    @(negedge clkin);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_reset_regs", {hsync[i], vsync[i], valid[i], vga_r[i], vga_g[i], vga_b[i]},
            {3'b110, 24'h0});
      check("async_reset_stage0", {rd_en[i], h_addr[i], v_addr[i], frame_start[i]}, 22'h0);
    end
    model_reset();
    repeat (3) cycle(1'b1);
    rst = 1'b1;
    repeat (2000) cycle(1'b1);
    check("sb_drain", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- VGA 640x480@60 Hz timing generator and pixel output stage. It sits directly downstream of the team's clock generator/divider, which supplies the pixel-rate enable.
- Produces hsync/vsync and pixel coordinates, and issues read addresses to the frame memory.
- Registers returned pixel data onto the RGB outputs, aligned with the syncs.

Parameters:
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, horizontal visible pixels
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, vertical visible lines
- V_FRONT, 10, vertical front porch

Ports:
- clkin  input  1  system clock; all state on its rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- pclk_en  input  1  pixel-rate enable from the clock divider; state advances only when it is 1
- vga_data  input  24  pixel {R[23:16],G[15:8],B[7:0]} returned for the previously presented address
- h_addr  output  10  visible column 0..639; 0 outside active
- v_addr  output  10  visible row 0..479; 0 outside active
- rd_en  output  1  current counter position is in the active region
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- valid  output  1  RGB outputs carry a visible pixel
- vga_r / vga_g / vga_b  output  8 each  colour outputs
- frame_start  output  1  one-clkin pulse when the counters wrap to (0,0)

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (800); v_cnt runs 0..V_TOTAL-1 (525). Both are 10-bit.
  - Both update only on a clkin edge with pclk_en=1. With pclk_en=0, every register holds.
  - h_cnt wraps 799->0 and increments v_cnt. At v_cnt=524 with h_cnt=799, both go to 0.
- Horizontal regions:
  - sync [0,96); back porch [96,144); active [144,784); front porch [784,800).
- Vertical regions:
  - sync [0,2); back porch [2,35); active [35,515); front porch [515,525).
- Stage 0 (combinational from counters):
  - rd_en = h_active & v_active.
  - h_addr = h_cnt-144 and v_addr = v_cnt-35 when rd_en=1; both 0 otherwise.
- Memory contract: vga_data for the address presented must be stable by the next pclk_en edge.
- Stage 1 (registered on pclk_en):
  - hsync = ~(h_cnt<96) and vsync = ~(v_cnt<2), taken from the pre-update counter values.
  - valid = rd_en.
  - RGB = vga_data if rd_en, else 0.
  - Fixed latency: outputs lag the counters by exactly one pixel enable. Syncs and RGB stay mutually aligned.
- frame_start: registered; 1 for exactly one clkin cycle following the pclk_en edge at which (799,524)->(0,0). 0 otherwise.
- Reset values:
  - h_cnt=0, v_cnt=0.
  - hsync=1, vsync=1, valid=0, RGB=0, frame_start=0.
  - h_addr/v_addr/rd_en follow the counters, so they are 0, 0, 0.
- Reset mid-frame: all state clears immediately and asynchronously. The first pclk_en after release advances h_cnt to 1; no partial frame is preserved.
- pclk_en tied 1: the block runs at clkin rate with no other change.
- Arithmetic: address subtraction is 10-bit unsigned and is evaluated only inside the active region, so there is no underflow.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- With the macro defined:
  - Extra input pattern_sel (1 bit) is present.
  - When pattern_sel=1, stage-1 RGB during active takes 8 vertical bars of 80 px each, selected by h_addr thresholds 80/160/.../560.
  - Bar colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - vga_data is ignored while pattern_sel=1. rd_en still toggles as normal.
- Without the macro: the port is absent and RGB always comes from vga_data.

Decomposition:
- Package vga_pkg holds:
  - the timing constants and the derived H_TOTAL/V_TOTAL and region boundaries;
  - the rgb24 typedef (packed r,g,b bytes);
  - the test-pattern colour constants.
- Sub-module vga_timing_cnt holds the h/v counters and region decode (rd_en, sync, addresses, wrap flag).
- vga_ctrl holds stage 1, frame_start and the optional pattern.

Test Plan:
- Reset, then pclk_en=1 continuously -> hsync low for exactly 96 pixels per 800-pixel line; vsync low for exactly 2 lines (1600 enables) per 525-line frame; frame_start pulses every 420000 enables.
- At the enable where h_cnt=144, v_cnt=35 -> rd_en=1, h_addr=0, v_addr=0. With vga_data=0x123456, the next enable gives valid=1, R=0x12, G=0x34, B=0x56. At h_cnt=783, h_addr=639; at h_cnt=784, rd_en=0.
- pclk_en pulsing 1-in-2 -> all counts advance at half rate; outputs are identical to the previous case per enable; registers hold when pclk_en=0.
- Wrap (799,524) -> next enable gives (0,0) and frame_start=1 for exactly one clkin cycle; vsync falls on the following enable.
- Assert rst=0 mid-line at h_cnt=300 -> outputs immediately go to hsync=1, vsync=1, valid=0, RGB=0; after release, timing restarts from (0,0).
- VGA_TEST_PATTERN_EN with pattern_sel=1 -> at h_addr=0, 79, 80 and 639 the RGB is FFFFFF, FFFFFF, FFFF00 and 000000 respectively.
